nn_infer_ctrl: RTL and testbench
================================

// Module: nn_infer_ctrl
// PURPOSE
//  Sequencer for the two-layer matmul inference datapath.
//  - Accepts a start handshake, then releases the layer-1 and layer-2 matmul resets in order.
//  - Waits for each layer's finished pulse, then runs a serial signed argmax over the class scores.
//  - Reports the winning digit, a per-run cycle count and a watchdog timeout error.
//  Replaces the reset-chaining and edge-triggered argmax glue in the top level; sits between top level and both matmuls.
// PARAMETERS
//  NUM_CLASSES    10    number of layer-2 outputs scanned by argmax
//  CLS_W          4     width of class index / score address (>= clog2(NUM_CLASSES))
//  SCORE_W        32    signed fixed-point score width
//  TIMEOUT_CYCLES 4096  watchdog limit, cycles from run accept to mm2_finished
//  CNT_W          13    cycle counter width (>= clog2(TIMEOUT_CYCLES+NUM_CLASSES+4))
// PORTS
//  clk           in   1        system clock, all logic on rising edge
//  reset         in   1        asynchronous, active-high; returns block to IDLE
//  start         in   1        run request; accepted when start & ready
//  ready         out  1        high only in IDLE
//  mm1_rst       out  1        reset to layer-1 matmul (registered)
//  mm2_rst       out  1        reset to layer-2 matmul (registered)
//  mm1_finished  in   1        layer-1 done level/pulse
//  mm2_finished  in   1        layer-2 done level/pulse
//  score_addr    out  CLS_W    class score read address
//  score_data    in   SCORE_W  signed score; valid 1 cycle after score_addr
//  digit_out     out  CLS_W    argmax result
//  digit_valid   out  1        digit_out valid; held until next accept
//  timeout_err   out  1        sticky watchdog flag; cleared on next accept
//  cycle_count   out  CNT_W    cycles from accept to DONE or ERR; saturating, held
// BEHAVIOUR
//  - Reset values (asynchronous, immediate):
//    - state=IDLE, mm1_rst=1, mm2_rst=1, score_addr=0, digit_out=0.
//    - digit_valid=0, timeout_err=0, cycle_count=0.
//  - States: IDLE, L1, L2, ARGMAX, DONE, ERR. All outputs are registered except ready (= state==IDLE).
//  - IDLE:
//    - Both rsts=1. On start&ready: clear digit_valid, timeout_err and cycle_count, go to L1.
//    - mm1_rst=0 from the first L1 cycle.
//  - L1:
//    - mm2_rst=1. On mm1_finished go to L2, with mm2_rst=0 from the first L2 cycle.
//    - mm1_rst stays 0 because layer-1 results must stay readable.
//  - L2: on mm2_finished go to ARGMAX, score_addr=0. mm1_finished is ignored.
//  - ARGMAX:
//    - Issue score_addr 0..NUM_CLASSES-1, one per cycle.
//    - Score k is compared in the cycle after address k; index 0 initialises max.
//    - Update only on strictly greater ($signed) score, so ties go to the lowest index.
//    - After compare NUM_CLASSES-1, go to DONE.
//    - Latency = NUM_CLASSES+1 cycles from ARGMAX entry.
//  - DONE (1 cycle):
//    - digit_out and digit_valid=1 registered; both rsts=1; go to IDLE.
//    - Start is accepted no earlier than the cycle after DONE.
//  - Watchdog:
//    - cycle_count increments every cycle in L1, L2 and ARGMAX, saturating at all-ones.
//    - If still in L1 or L2 when cycle_count == TIMEOUT_CYCLES-1: go to ERR.
//  - ERR (1 cycle):
//    - timeout_err=1, both rsts=1, digit_valid stays 0; go to IDLE.
//  - Boundary cases:
//    - start outside IDLE is ignored, no queueing.
//    - mm1_finished and mm2_finished high together in L1: go to L2 only; mm2_finished is acted on in L2.
//    - mm2_finished in L1 is ignored.
//    - Finished inputs in IDLE, ARGMAX or DONE are ignored.
//    - Timeout and finished in the same cycle: finished wins.
//    - reset mid-run: immediate return to reset values; any partial argmax is discarded.
// STRUCTURE
//  - Shared package nn_pkg holds: state encoding localparams, NUM_CLASSES, CLS_W and SCORE_W defaults,
//    fixed-point format constants.
//  - One sub-module: nn_argmax_serial. Inputs: clk, reset, clr, en, idx, score. Outputs: max_idx, max_val.
//    Holds the running max register and the strict-greater compare.
//  - FSM, watchdog and reset drivers stay in nn_infer_ctrl.
// TESTING
//  - Power-on: assert reset, release -> ready=1, mm1_rst=mm2_rst=1, digit_valid=0, timeout_err=0.
//  - Nominal run:
//    - start; mm1_finished after 800 cycles; mm2_finished after 120 more.
//    - Scores {-5,3,7,2,7,0,-1,1,4,6} -> digit_out=2, digit_valid=1.
//    - cycle_count = 800+120+11 (+/-1 per FSM entry convention, documented in bench).
//  - All-negative scores {-9,-3,-3,-8,...} -> digit_out=1 (tie to lowest index, signed compare).
//  - Watchdog: start, never assert mm1_finished -> ERR at cycle 4095; timeout_err=1, both rsts=1;
//    next start clears timeout_err.
//  - Mid-run reset: reset during ARGMAX at score_addr=5 -> immediately all reset values; no digit_valid.
//  - Protocol abuse: start pulses during L1/L2; mm2_finished during L1; both finished in one cycle
//    -> exactly one run, correct digit, no early ARGMAX.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the two-layer inference sequencer.
// Holds default sizing, the score fixed-point format and the sequencer state encoding.
package nn_pkg;

  // Default sizing
  localparam int unsigned NUM_CLASSES    = 10;
  localparam int unsigned CLS_W          = 4;
  localparam int unsigned SCORE_W        = 32;
  localparam int unsigned TIMEOUT_CYCLES = 4096;
  localparam int unsigned CNT_W          = 13;

  // Scores are signed Q16.16 fixed point; argmax only needs the ordering, not the scale
  localparam int unsigned SCORE_FRAC_W = 16;
  localparam int unsigned SCORE_INT_W  = SCORE_W - SCORE_FRAC_W;
  localparam logic signed [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1) << SCORE_FRAC_W;

  // Sequencer state encoding
  localparam logic [2:0] ENC_IDLE   = 3'd0;
  localparam logic [2:0] ENC_L1     = 3'd1;
  localparam logic [2:0] ENC_L2     = 3'd2;
  localparam logic [2:0] ENC_ARGMAX = 3'd3;
  localparam logic [2:0] ENC_DONE   = 3'd4;
  localparam logic [2:0] ENC_ERR    = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = ENC_IDLE,
    ST_L1     = ENC_L1,
    ST_L2     = ENC_L2,
    ST_ARGMAX = ENC_ARGMAX,
    ST_DONE   = ENC_DONE,
    ST_ERR    = ENC_ERR
  } state_t;

endpackage

// File: rtl/nn_argmax_serial.sv
// Serial signed argmax: one (idx, score) pair per enabled cycle.
// Index 0 loads unconditionally; later indices replace the running max only
// when strictly greater, so ties keep the lowest index.
// Ports:
//   clk, reset      clock, async active-high reset
//   clr             synchronous clear of the running max
//   en              compare/update enable for this cycle
//   idx, score      candidate class index and its signed score
//   max_idx         index of the current maximum
//   max_val         current maximum score
module nn_argmax_serial
  import nn_pkg::*;
#(
  parameter int unsigned CLS_W   = nn_pkg::CLS_W,
  parameter int unsigned SCORE_W = nn_pkg::SCORE_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clr,
  input  logic                      en,
  input  logic [CLS_W-1:0]          idx,
  input  logic signed [SCORE_W-1:0] score,
  output logic [CLS_W-1:0]          max_idx,
  output logic signed [SCORE_W-1:0] max_val
);

  logic take;

  // Strict-greater signed compare; first element seeds the max
  always_comb begin
    take = 1'b0;
    if (en) begin
      take = (idx == '0) || (score > max_val);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_idx <= '0;
      max_val <= '0;
    end else if (clr) begin
      max_idx <= '0;
      max_val <= '0;
    end else if (take) begin
      max_idx <= idx;
      max_val <= score;
    end
  end

endmodule

// File: rtl/nn_infer_ctrl.sv
// Sequencer for the two-layer matmul inference datapath.
// Accepts a run, releases the layer-1 then layer-2 matmul resets, waits for each
// finished pulse, scans the class scores for a signed argmax and reports the digit,
// a per-run cycle count and a watchdog timeout.
// Ports:
//   clk, reset                  clock, async active-high reset
//   start / ready               run request, accepted when start & ready (ready = IDLE)
//   mm1_rst, mm2_rst            registered resets to the layer-1 / layer-2 matmuls
//   mm1_finished, mm2_finished  layer done indications
//   score_addr / score_data     class score read port (data one cycle after address)
//   digit_out, digit_valid      argmax result, valid held until next accept
//   timeout_err                 sticky watchdog flag, cleared on next accept
//   cycle_count                 cycles from accept to DONE/ERR, saturating, held
module nn_infer_ctrl
  import nn_pkg::*;
#(
  parameter int unsigned NUM_CLASSES    = nn_pkg::NUM_CLASSES,
  parameter int unsigned CLS_W          = nn_pkg::CLS_W,
  parameter int unsigned SCORE_W        = nn_pkg::SCORE_W,
  parameter int unsigned TIMEOUT_CYCLES = nn_pkg::TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = nn_pkg::CNT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      ready,
  output logic                      mm1_rst,
  output logic                      mm2_rst,
  input  logic                      mm1_finished,
  input  logic                      mm2_finished,
  output logic [CLS_W-1:0]          score_addr,
  input  logic signed [SCORE_W-1:0] score_data,
  output logic [CLS_W-1:0]          digit_out,
  output logic                      digit_valid,
  output logic                      timeout_err,
  output logic [CNT_W-1:0]          cycle_count
);

  // One extra bit so the scan phase can reach NUM_CLASSES even when it is a power of two
  localparam int unsigned PH_W = CLS_W + 1;

  state_t            state, state_nxt;
  logic              mm1_rst_nxt, mm2_rst_nxt;
  logic [CLS_W-1:0]  score_addr_nxt, digit_out_nxt;
  logic              digit_valid_nxt, timeout_err_nxt;
  logic [CNT_W-1:0]  cycle_count_nxt;
  logic [PH_W-1:0]   scan_cnt, scan_cnt_nxt;
  logic              wd_hit;

  logic                      am_clr, am_en;
  logic [CLS_W-1:0]          am_idx;
  logic [CLS_W-1:0]          max_idx;
  logic signed [SCORE_W-1:0] max_val_unused;

  assign ready  = (state == ST_IDLE);
  assign wd_hit = (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));

  nn_argmax_serial #(
    .CLS_W   (CLS_W),
    .SCORE_W (SCORE_W)
  ) u_argmax (
    .clk     (clk),
    .reset   (reset),
    .clr     (am_clr),
    .en      (am_en),
    .idx     (am_idx),
    .score   (score_data),
    .max_idx (max_idx),
    .max_val (max_val_unused)
  );

  // Next-state and next-output logic
  always_comb begin
    state_nxt       = state;
    mm1_rst_nxt     = mm1_rst;
    mm2_rst_nxt     = mm2_rst;
    score_addr_nxt  = score_addr;
    digit_out_nxt   = digit_out;
    digit_valid_nxt = digit_valid;
    timeout_err_nxt = timeout_err;
    cycle_count_nxt = cycle_count;
    scan_cnt_nxt    = scan_cnt;
    am_clr          = 1'b0;
    am_en           = 1'b0;
    am_idx          = '0;

    // Watchdog / run-length counter runs while a run is in flight
    if ((state == ST_L1 || state == ST_L2 || state == ST_ARGMAX) &&
        (cycle_count != {CNT_W{1'b1}})) begin
      cycle_count_nxt = cycle_count + CNT_W'(1);
    end

    case (state)
      ST_IDLE: begin
        mm1_rst_nxt = 1'b1;
        mm2_rst_nxt = 1'b1;
        if (start) begin
          state_nxt       = ST_L1;
          mm1_rst_nxt     = 1'b0;
          digit_valid_nxt = 1'b0;
          timeout_err_nxt = 1'b0;
          cycle_count_nxt = '0;
          am_clr          = 1'b1;
        end
      end

      // Layer 1 running; mm2_finished here is stale and ignored
      ST_L1: begin
        mm2_rst_nxt = 1'b1;
        if (mm1_finished) begin
          state_nxt   = ST_L2;
          mm2_rst_nxt = 1'b0;
        end else if (wd_hit) begin
          state_nxt       = ST_ERR;
          mm1_rst_nxt     = 1'b1;
          mm2_rst_nxt     = 1'b1;
          timeout_err_nxt = 1'b1;
        end
      end

      // Layer 2 running; mm1 stays out of reset so its results remain readable
      ST_L2: begin
        if (mm2_finished) begin
          state_nxt      = ST_ARGMAX;
          score_addr_nxt = '0;
          scan_cnt_nxt   = '0;
        end else if (wd_hit) begin
          state_nxt       = ST_ERR;
          mm1_rst_nxt     = 1'b1;
          mm2_rst_nxt     = 1'b1;
          timeout_err_nxt = 1'b1;
        end
      end

      // Phase p issues address p (p < NUM_CLASSES) and compares the score of address p-1
      ST_ARGMAX: begin
        am_en  = (scan_cnt != '0);
        am_idx = CLS_W'(scan_cnt - PH_W'(1));
        if (scan_cnt == PH_W'(NUM_CLASSES)) begin
          state_nxt   = ST_DONE;
          mm1_rst_nxt = 1'b1;
          mm2_rst_nxt = 1'b1;
        end else begin
          scan_cnt_nxt = scan_cnt + PH_W'(1);
          if (scan_cnt < PH_W'(NUM_CLASSES - 1)) begin
            score_addr_nxt = score_addr + CLS_W'(1);
          end
        end
      end

      ST_DONE: begin
        digit_out_nxt   = max_idx;
        digit_valid_nxt = 1'b1;
        mm1_rst_nxt     = 1'b1;
        mm2_rst_nxt     = 1'b1;
        state_nxt       = ST_IDLE;
      end

      ST_ERR: begin
        mm1_rst_nxt = 1'b1;
        mm2_rst_nxt = 1'b1;
        state_nxt   = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      mm1_rst     <= 1'b1;
      mm2_rst     <= 1'b1;
      score_addr  <= '0;
      digit_out   <= '0;
      digit_valid <= 1'b0;
      timeout_err <= 1'b0;
      cycle_count <= '0;
      scan_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      mm1_rst     <= mm1_rst_nxt;
      mm2_rst     <= mm2_rst_nxt;
      score_addr  <= score_addr_nxt;
      digit_out   <= digit_out_nxt;
      digit_valid <= digit_valid_nxt;
      timeout_err <= timeout_err_nxt;
      cycle_count <= cycle_count_nxt;
      scan_cnt    <= scan_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_nn_infer_ctrl.sv
// Self-checking bench for nn_infer_ctrl.
// The reference model timestamps each run: t counts cycles since accept (t=0 is the
// first L1 cycle), t1/t2 are the first L2/ARGMAX cycles and err_t the ERR cycle.
// Expected outputs follow from those timestamps. cycle_count equals t throughout the
// run, so a run ending in DONE reports l1+l2+11 and a watchdog run reports 4096
// (the L1 cycle that sees count 4095 still counts once more before ERR).
module tb_nn_infer_ctrl;
  import nn_pkg::*;

  localparam int NC = NUM_CLASSES;
  localparam int TO = TIMEOUT_CYCLES;
  localparam int P_IDLE = 0, P_L1 = 1, P_L2 = 2, P_ARG = 3, P_DONE = 4, P_ERR = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start, mm1_finished, mm2_finished;
  logic ready, mm1_rst, mm2_rst, digit_valid, timeout_err;
  logic [CLS_W-1:0] score_addr, digit_out;
  logic signed [SCORE_W-1:0] score_data;
  logic [CNT_W-1:0] cycle_count;

  logic signed [SCORE_W-1:0] scores [NC];
  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // Reference model state
  bit run = 1'b0;
  int t = 0, t1 = -1, t2 = -1, err_t = -1;
  int exp_digit = 0, digit_hold = 0, cnt_hold = 0;
  bit dv_hold = 1'b0, terr_hold = 1'b0, post_rst = 1'b0;
  int ph_now;

  nn_infer_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .ready        (ready),
    .mm1_rst      (mm1_rst),
    .mm2_rst      (mm2_rst),
    .mm1_finished (mm1_finished),
    .mm2_finished (mm2_finished),
    .score_addr   (score_addr),
    .score_data   (score_data),
    .digit_out    (digit_out),
    .digit_valid  (digit_valid),
    .timeout_err  (timeout_err),
    .cycle_count  (cycle_count)
  );

  always #5 clk = ~clk;

  // Score memory: one-cycle read latency
  always @(posedge clk)
    score_data <= (int'(score_addr) < NC) ? scores[int'(score_addr)] : '0;

  function automatic int phase_of(input int tt, input int a1, input int a2, input int ae);
    if (ae >= 0 && tt >= ae) return P_ERR;
    if (a1 < 0 || tt < a1) return P_L1;
    if (a2 < 0 || tt < a2) return P_L2;
    if (tt < a2 + NC + 1) return P_ARG;
    return P_DONE;
  endfunction

  // Lowest index among the maximal signed scores
  function automatic int argmax_ref();
    int best = 0;
    for (int i = 1; i < NC; i++)
      if (scores[i] > scores[best]) best = i;
    return best;
  endfunction

  assign ph_now = run ? phase_of(t, t1, t2, err_t) : P_IDLE;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advances once per clock using the inputs of the finished cycle
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      run <= 1'b0; dv_hold <= 1'b0; terr_hold <= 1'b0;
      cnt_hold <= 0; digit_hold <= 0; post_rst <= 1'b1;
    end else if (!run) begin
      if (start) begin
        run <= 1'b1; t <= 0; t1 <= -1; t2 <= -1; err_t <= -1;
        dv_hold <= 1'b0; terr_hold <= 1'b0; post_rst <= 1'b0;
        exp_digit <= argmax_ref();
      end
    end else begin
      if (ph_now == P_L1) begin
        if (mm1_finished) t1 <= t + 1;
        else if (t == TO - 1) err_t <= t + 1;
      end else if (ph_now == P_L2) begin
        if (mm2_finished) t2 <= t + 1;
        else if (t == TO - 1) err_t <= t + 1;
      end else if (ph_now == P_DONE) begin
        run <= 1'b0; dv_hold <= 1'b1; digit_hold <= exp_digit; cnt_hold <= t;
      end else if (ph_now == P_ERR) begin
        run <= 1'b0; terr_hold <= 1'b1; cnt_hold <= t;
      end
      t <= t + 1;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", int'(ready), run ? 0 : 1);
      chk("mm1_rst", int'(mm1_rst),
          (ph_now == P_L1 || ph_now == P_L2 || ph_now == P_ARG) ? 0 : 1);
      chk("mm2_rst", int'(mm2_rst), (ph_now == P_L2 || ph_now == P_ARG) ? 0 : 1);
      chk("digit_valid", int'(digit_valid), run ? 0 : int'(dv_hold));
      chk("timeout_err", int'(timeout_err), run ? int'(ph_now == P_ERR) : int'(terr_hold));
      chk("cycle_count", int'(cycle_count), run ? t : cnt_hold);
      if (ph_now == P_ARG)
        chk("score_addr", int'(score_addr), (t - t2 > NC - 1) ? NC - 1 : t - t2);
      if (!run && dv_hold)
        chk("digit_out", int'(digit_out), digit_hold);
      if (!run && post_rst) begin
        chk("rst_score_addr", int'(score_addr), 0);
        chk("rst_digit_out", int'(digit_out), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mm1_finished pulses in L1 cycle d-1; optional stray start/mm2 pulses before it
  task automatic run_l1(input int d, input bit abuse, input bit both);
    for (int i = 0; i < d - 1; i++) begin
      start        = abuse && ($urandom_range(0, 5) == 0);
      mm2_finished = abuse && ($urandom_range(0, 5) == 0);
      tick();
    end
    start = 1'b0; mm1_finished = 1'b1; mm2_finished = both;
    tick();
    mm1_finished = 1'b0; mm2_finished = 1'b0;
  endtask

  // mm2_finished pulses d cycles after L2 entry; optional stray start/mm1 pulses
  task automatic run_l2(input int d, input bit abuse);
    for (int i = 0; i < d - 1; i++) begin
      start        = abuse && ($urandom_range(0, 5) == 0);
      mm1_finished = abuse && ($urandom_range(0, 5) == 0);
      tick();
    end
    start = 1'b0; mm1_finished = 1'b0; mm2_finished = 1'b1;
    tick();
    mm2_finished = 1'b0;
  endtask

  task automatic wait_ready(input int max_cycles, input bit noise);
    int n = 0;
    while (!ready && n < max_cycles) begin
      start        = noise && ($urandom_range(0, 7) == 0);
      mm1_finished = noise && ($urandom_range(0, 3) == 0);
      mm2_finished = noise && ($urandom_range(0, 3) == 0);
      tick();
      n++;
    end
    start = 1'b0; mm1_finished = 1'b0; mm2_finished = 1'b0;
    chk("wait_ready", int'(ready), 1);
  endtask

  task automatic load_nominal();
    int v [NC] = '{-5, 3, 7, 2, 7, 0, -1, 1, 4, 6};
    for (int i = 0; i < NC; i++) scores[i] = SCORE_W'(v[i]);
  endtask

  initial begin
    int l1, l2;
    int neg [NC] = '{-9, -3, -3, -8, -20, -4, -5, -7, -6, -10};
    start = 1'b0; mm1_finished = 1'b0; mm2_finished = 1'b0;
    for (int i = 0; i < NC; i++) scores[i] = '0;

    // Power-on
    #1 reset = 1'b1;
    chk_en = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("por_ready", int'(ready), 1);
    chk("por_mm1_rst", int'(mm1_rst), 1);
    chk("por_mm2_rst", int'(mm2_rst), 1);
    chk("por_digit_valid", int'(digit_valid), 0);
    chk("por_timeout_err", int'(timeout_err), 0);

    // Nominal run: 800 + 120 + 11 cycles
    load_nominal();
    do_start();
    run_l1(800, 1'b0, 1'b0);
    run_l2(120, 1'b0);
    wait_ready(40, 1'b0);
    chk("nom_digit", int'(digit_out), 2);
    chk("nom_valid", int'(digit_valid), 1);
    chk("nom_cycles", int'(cycle_count), 931);

    // All-negative scores: tie between 1 and 2 goes to 1
    for (int i = 0; i < NC; i++) scores[i] = SCORE_W'(neg[i]);
    do_start();
    run_l1(5, 1'b0, 1'b0);
    run_l2(3, 1'b0);
    wait_ready(40, 1'b0);
    chk("neg_digit", int'(digit_out), 1);
    chk("neg_cycles", int'(cycle_count), 19);

    // Protocol abuse: stray starts/finishes, both finished together in L1
    load_nominal();
    do_start();
    run_l1(40, 1'b1, 1'b1);
    run_l2(25, 1'b1);
    wait_ready(40, 1'b1);
    chk("abuse_digit", int'(digit_out), 2);
    chk("abuse_cycles", int'(cycle_count), 76);

    // Watchdog: layer 1 never finishes
    do_start();
    wait_ready(TO + 20, 1'b0);
    chk("wd_timeout_err", int'(timeout_err), 1);
    chk("wd_cycles", int'(cycle_count), 4096);
    chk("wd_digit_valid", int'(digit_valid), 0);
    do_start();
    chk("wd_clear", int'(timeout_err), 0);
    run_l1(3, 1'b0, 1'b0);
    run_l2(2, 1'b0);
    wait_ready(40, 1'b0);
    chk("wd_recover_digit", int'(digit_out), 2);

    // Reset in the middle of the score scan
    for (int i = 0; i < NC; i++) scores[i] = SCORE_W'($urandom);
    do_start();
    run_l1(4, 1'b0, 1'b0);
    run_l2(4, 1'b0);
    begin
      int n = 0;
      while (score_addr != CLS_W'(5) && n < 20) begin tick(); n++; end
    end
    chk("kill_addr", int'(score_addr), 5);
    reset = 1'b1;
    #1;
    chk("kill_ready", int'(ready), 1);
    chk("kill_mm1_rst", int'(mm1_rst), 1);
    chk("kill_mm2_rst", int'(mm2_rst), 1);
    chk("kill_score_addr", int'(score_addr), 0);
    chk("kill_digit_valid", int'(digit_valid), 0);
    chk("kill_cycles", int'(cycle_count), 0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("kill_no_valid", int'(digit_valid), 0);

    // Randomized runs
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < NC; i++)
        scores[i] = (r % 2 == 0) ? SCORE_W'(int'($urandom_range(0, 8)) - 4) : SCORE_W'($urandom);
      l1 = int'($urandom_range(1, 30));
      l2 = int'($urandom_range(1, 30));
      do_start();
      run_l1(l1, 1'(r % 3 != 0), 1'($urandom_range(0, 1)));
      run_l2(l2, 1'(r % 3 != 0));
      wait_ready(40, 1'(r % 2));
      repeat (int'($urandom_range(0, 3))) tick();
    end

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
